// File: rtl/stream_arb_2_1_if.sv
// One valid/ready stream channel carrying a data beat and a packet-final flag.
// The producer uses the master modport; the consumer uses the slave modport.
interface stream_arb_2_1_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/stream_arb_2_1.sv
// Two-input round-robin stream arbiter that keeps the grant for a whole packet
// and drives the shared channel from a single registered output stage.
module stream_arb_2_1 #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_arb_2_1_if.slave         in0,
  stream_arb_2_1_if.slave         in1,
  stream_arb_2_1_if.master        out_ch,
  output logic                    out_src,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;

  logic space;
  logic grant0, grant1;
  logic xfer0, xfer1;

  // The output register can take a beat when empty or when it drains this cycle.
  assign space = !out_valid_q || out_ch.ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = in0.valid && (!prio_q || !in1.valid);
        grant1 = in1.valid && ( prio_q || !in0.valid);
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign in0.ready = space && grant0;
  assign in1.ready = space && grant1;
  assign xfer0     = in0.valid && in0.ready;
  assign xfer1     = in1.valid && in1.ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (xfer0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0.data;
      out_last_d  = in0.last;
      out_src_d   = 1'b0;
      if (in0.last) begin
        state_d = IDLE;
        prio_d  = 1'b1;
      end else begin
        state_d = LOCK0;
      end
    end else if (xfer1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1.data;
      out_last_d  = in1.last;
      out_src_d   = 1'b1;
      if (in1.last) begin
        state_d = IDLE;
        prio_d  = 1'b0;
      end else begin
        state_d = LOCK1;
      end
    end else if (out_valid_q && out_ch.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_ch.valid = out_valid_q;
  assign out_ch.data  = out_data_q;
  assign out_ch.last  = out_last_q;
  assign out_src      = out_src_q;
  assign busy         = (state_q == LOCK0) || (state_q == LOCK1);

endmodule

// File: doc/stream_arb_2_1.md
Name: stream_arb_2_1

Overview:
- Two-input, round-robin, packet-locked stream arbiter with a registered output stage.
- Sits directly upstream of the 2:1 mux select path.
  - Decides which of two sources owns the shared channel.
  - Steers that source's beats to a single output.
  - Publishes the owning source index on out_src.
- The grant is held for a whole packet (until a beat with last=1 is accepted); priority then rotates to the other source.

Parameters:
WIDTH, 8, data bits per beat on each input and on the output.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in0_data  input  WIDTH  source 0 beat data
in0_last  input  1  source 0 final beat of packet
in0_valid  input  1  source 0 beat present
in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid
in1_data  input  WIDTH  source 1 beat data
in1_last  input  1  source 1 final beat of packet
in1_valid  input  1  source 1 beat present
in1_ready  output  1  source 1 beat accepted this cycle when high with in1_valid
out_data  output  WIDTH  registered output beat
out_last  output  1  registered last flag
out_src  output  1  index of the source that produced the current output beat
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts output beat
busy  output  1  high while a packet is locked (state != IDLE)

Behaviour:
- Reset (async, immediate on rst=1): out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, prio=0 (source 0 wins the first tie). All in-flight beats and any partial packet are discarded.
- space = !out_valid || out_ready. This is combinational, so a full output register drained this cycle can refill this cycle.
- Transfer rules:
  - An input beat transfers when inX_valid && inX_ready at the rising edge.
  - The output beat transfers when out_valid && out_ready.
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - pick0 = in0_valid && (prio==0 || !in1_valid).
  - pick1 = in1_valid && (prio==1 || !in0_valid).
  - in0_ready = space && pick0; in1_ready = space && pick1. At most one is high.
  - On transfer from X:
    - If last=0: go to LOCKX.
    - If last=1: stay IDLE and set prio = !X.
- LOCKX:
  - inX_ready = space; the other input's ready = 0 regardless of its valid.
  - On transfer from X with last=1: go to IDLE and set prio = !X.
  - On transfer from X with last=0: stay in LOCKX.
  - Beats with inX_valid=0 (bubbles) inside a packet keep the lock.
- Output register:
  - On any input transfer: out_data, out_last, out_src load from the granted source, and out_valid=1 at the next edge. Latency is exactly 1 cycle.
  - With no input transfer and an output transfer: out_valid=0 at the next edge.
  - While out_valid && !out_ready: out_data, out_last and out_src hold stable, and both in*_ready=0.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- busy = (state==LOCK0 || state==LOCK1). busy is a combinational decode of the registered state.
- No data width conversion; data passes bit-exact.
- If both inputs are valid in IDLE, exactly one wins per prio; the loser's ready=0 and its data must stay unconsumed.

Test Plan:
- Reset mid-packet:
  - Stimulus: in0 sends a 3-beat packet (0x11, 0x12, 0x13/last); assert rst after beat 2 is accepted.
  - Response: out_valid=0 and busy=0 immediately.
  - After rst=0, a new in1 single beat 0x55/last is granted, and out_src=1.
- Single source, single beats:
  - Stimulus: in0 sends 0xA1, 0xA2, 0xA3, each last=1, out_ready=1.
  - Response: out_data = A1, A2, A3 on consecutive cycles, one cycle after each accept; out_src=0; busy stays 0.
- Tie rotation:
  - Stimulus: in0 (0x10..) and in1 (0x20..) are both continuously valid with single-beat packets.
  - Response: output alternates 0x10, 0x20, 0x11, 0x21, starting with source 0 after reset.
- Packet lock:
  - Stimulus: in0 sends a 4-beat packet (0x30..0x33, last on 0x33) while in1 is valid with 0x40/last throughout.
  - Response: in1_ready=0 for all four beats; busy=1 from after beat 0x30 until 0x33 is accepted; 0x40 appears next with out_src=1.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1 holding 0x5A.
  - Response: out_data stays 0x5A and in0_ready=in1_ready=0 during the stall.
  - Response: on out_ready=1, 0x5A and the next beat transfer on back-to-back cycles with no bubble.
- Bubble inside lock:
  - Stimulus: in1 packet 0x60, gap of 2 cycles (in1_valid=0), then 0x61/last, while in0 is valid throughout.
  - Response: in0_ready stays 0 through the gap; busy=1 throughout; in0 is granted only after 0x61 is accepted.
